// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: request/response handshakes and SRAM macro pins of the port arbiter
// Signals: wr_valid/wr_ready/wr_addr/wr_data (write request), rd_valid/rd_ready/rd_addr (read request),
// resp_valid/resp_ready/resp_data (read response), sram_ceb/sram_web/sram_a/sram_d/sram_q (macro pins,
// enables active-low), init_done (array usable).
// Modports: slave = arbiter side, master = requester/macro side.
interface sram_port_arbiter_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 3
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              sram_ceb;
   logic              sram_web;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q;
   logic              init_done;
   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_q,
      output wr_ready, rd_ready, resp_valid, resp_data, sram_ceb, sram_web, sram_a, sram_d, init_done
   );
   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_q,
      input  wr_ready, rd_ready, resp_valid, resp_data, sram_ceb, sram_web, sram_a, sram_d, init_done
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: arbitrates one write port and one read port onto a single-port SRAM macro
// Ports: i_clk (rising edge), i_rst (asynchronous, active-high), bus (sram_port_arbiter_if.slave):
// write/read request handshakes, one-deep read response slot, macro ceb/web/a/d/q, init_done.
// Optional macro SRAM_ARB_INIT_EN: zero-fills the array after reset (one word per cycle) before
// any request is accepted; without it the block runs from the first cycle after reset.
module sram_port_arbiter #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input logic                i_clk,
   input logic                i_rst,
   sram_port_arbiter_if.slave bus
);
   if (ADDR_W != $clog2(DEPTH)) begin : g_bad_cfg
      $error("ADDR_W must equal log2(DEPTH)");
   end
   logic              r_prio_rd;
   logic              r_inflight;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic              w_run;
   logic              w_init_wr;
   logic [ADDR_W-1:0] w_init_a;
   logic              w_rd_open;
   logic              w_wr_elig;
   logic              w_rd_elig;
   logic              w_wr_go;
   logic              w_rd_go;
`ifdef SRAM_ARB_INIT_EN
   typedef enum logic {S_INIT, S_RUN} state_t;
   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_init_addr;
   logic [ADDR_W-1:0] w_init_addr_nxt;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_INIT;
         r_init_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_addr <= w_init_addr_nxt;
      end
   end
   // Reset is masked so the macro sees no write while reset is held.
   always_comb begin
      w_state_nxt     = r_state;
      w_init_addr_nxt = r_init_addr;
      w_init_wr       = 1'b0;
      if (r_state == S_INIT && !i_rst) begin
         w_init_wr       = 1'b1;
         w_init_addr_nxt = r_init_addr + ADDR_W'(1);
         w_state_nxt     = (r_init_addr == ADDR_W'(DEPTH - 1)) ? S_RUN : S_INIT;
      end
   end
   assign w_init_a      = r_init_addr;
   assign bus.init_done = (r_state == S_RUN);
`else
   assign w_init_wr     = 1'b0;
   assign w_init_a      = '0;
   assign bus.init_done = 1'b1;
`endif
   // Readies are gated by reset so both read 0 while it is asserted.
   assign w_run     = !i_rst && bus.init_done;
   assign w_rd_open = w_run && !r_inflight && (!r_resp_valid || bus.resp_ready);
   assign w_wr_elig = w_run && bus.wr_valid;
   assign w_rd_elig = w_rd_open && bus.rd_valid;
   // Each ready looks only at the other side's valid, never its own.
   assign bus.wr_ready = w_run && (!w_rd_elig || !r_prio_rd);
   assign bus.rd_ready = w_rd_open && (!w_wr_elig || r_prio_rd);
   assign w_wr_go      = bus.wr_valid && bus.wr_ready;
   assign w_rd_go      = bus.rd_valid && bus.rd_ready;
   assign bus.sram_ceb = !(w_init_wr || w_wr_go || w_rd_go);
   assign bus.sram_web = !(w_init_wr || w_wr_go);
   assign bus.sram_a   = w_init_wr ? w_init_a : w_wr_go ? bus.wr_addr : w_rd_go ? bus.rd_addr : '0;
   assign bus.sram_d   = w_wr_go ? bus.wr_data : '0;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   // r_inflight marks the cycle in which sram_q carries the read word; the slot is
   // always empty by then because a read is only issued into an empty or draining slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prio_rd    <= 1'b0;
         r_inflight   <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
      end else begin
         if (w_wr_elig && w_rd_elig) r_prio_rd <= !r_prio_rd;
         r_inflight <= w_rd_go;
         if (r_inflight) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= bus.sram_q;
         end else if (r_resp_valid && bus.resp_ready) begin
            r_resp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random checks of sram_port_arbiter against a request-level model
module tb_sram_port_arbiter;
   localparam int DW = 128;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam logic [DW-1:0] A5 = {16{8'hA5}};
   logic clk = 1'b0;
   logic rst = 1'b0;
   bit pre = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   sram_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
   sram_port_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus.slave)
   );
   function automatic logic [DW-1:0] seed_word(input int i);
      return {4{32'hC0DE_0000 + 32'(i)}};
   endfunction
   // Macro model: q only meaningful in the cycle after a read, garbage otherwise.
   logic [DW-1:0] sram_mem [DEPTH];
   always @(posedge clk) begin
      if (pre) for (int i = 0; i < DEPTH; i++) sram_mem[i] <= seed_word(i);
      else if (!bus.sram_ceb && !bus.sram_web) sram_mem[bus.sram_a] <= bus.sram_d;
      bus.sram_q <= (!bus.sram_ceb && bus.sram_web) ? sram_mem[bus.sram_a] : {$urandom, $urandom, $urandom, $urandom};
   end
   // Reference model: array contents, priority owner, one outstanding read (in flight or held).
   logic [DW-1:0] ref_mem [DEPTH];
   bit m_prio_rd, m_fl, m_held;
   logic [DW-1:0] m_fl_d, m_held_d;
   bit dut_gw, dut_gr;
   int dut_both = 0;
   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_prio_rd = 1'b0;
      m_fl = 1'b0;
      m_held = 1'b0;
   endtask
   task automatic chk_reset_outputs();
      logic exp_id;
`ifdef SRAM_ARB_INIT_EN
      exp_id = 1'b0;
`else
      exp_id = 1'b1;
`endif
      chk("rst_resp_valid", DW'(bus.resp_valid), '0);
      chk("rst_resp_data", bus.resp_data, '0);
      chk("rst_wr_ready", DW'(bus.wr_ready), '0);
      chk("rst_rd_ready", DW'(bus.rd_ready), '0);
      chk("rst_ceb", DW'(bus.sram_ceb), DW'(1));
      chk("rst_web", DW'(bus.sram_web), DW'(1));
      chk("rst_a", DW'(bus.sram_a), '0);
      chk("rst_d", bus.sram_d, '0);
      chk("rst_init_done", DW'(bus.init_done), DW'(exp_id));
   endtask
`ifdef SRAM_ARB_INIT_EN
   task automatic init_seq(input int n);
      bus.wr_valid = 1'b1;
      bus.rd_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk("init_ceb", DW'(bus.sram_ceb), '0);
         chk("init_web", DW'(bus.sram_web), '0);
         chk("init_a", DW'(bus.sram_a), DW'(i));
         chk("init_d", bus.sram_d, '0);
         chk("init_done_low", DW'(bus.init_done), '0);
         chk("init_wr_ready", DW'(bus.wr_ready), '0);
         chk("init_rd_ready", DW'(bus.rd_ready), '0);
         @(posedge clk); #1;
      end
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b0;
   endtask
`endif
   task automatic start_run();
`ifdef SRAM_ARB_INIT_EN
      init_seq(DEPTH);
      chk("init_done_rise", DW'(bus.init_done), DW'(1));
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
      @(posedge clk); #1;
`endif
   endtask
   task automatic release_rst();
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      start_run();
   endtask
   // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
   task automatic cycle(input bit wv, input bit rv, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                        input logic [DW-1:0] wd, input bit rr);
      bit open, ewr, erd, gw, gr;
      bus.wr_valid = wv;
      bus.rd_valid = rv;
      bus.wr_addr = wa;
      bus.rd_addr = ra;
      bus.wr_data = wd;
      bus.resp_ready = rr;
      open = !m_fl && (!m_held || rr);
      ewr = !(rv && open) || !m_prio_rd;
      erd = open && (!wv || m_prio_rd);
      gw = wv && ewr;
      gr = rv && erd;
      @(negedge clk);
      dut_gw = bus.wr_valid && bus.wr_ready;
      dut_gr = bus.rd_valid && bus.rd_ready;
      if (dut_gw && dut_gr) dut_both++;
      chk("wr_ready", DW'(bus.wr_ready), DW'(ewr));
      chk("rd_ready", DW'(bus.rd_ready), DW'(erd));
      chk("resp_valid", DW'(bus.resp_valid), DW'(m_held));
      if (m_held) chk("resp_data", bus.resp_data, m_held_d);
      chk("sram_ceb", DW'(bus.sram_ceb), DW'(!(gw || gr)));
      chk("sram_web", DW'(bus.sram_web), DW'(!gw));
      chk("sram_a", DW'(bus.sram_a), DW'(gw ? wa : gr ? ra : AW'(0)));
      chk("sram_d", bus.sram_d, gw ? wd : '0);
      chk("init_done", DW'(bus.init_done), DW'(1));
      @(posedge clk);
      if (gw) ref_mem[wa] = wd;
      if (m_held && rr) m_held = 1'b0;
      if (m_fl) begin
         m_held = 1'b1;
         m_held_d = m_fl_d;
      end
      m_fl = gr;
      if (gr) m_fl_d = ref_mem[ra];
      if (wv && rv && open) m_prio_rd = !m_prio_rd;
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [DW-1:0] snap;
      bus.wr_valid = 1'b1;
      bus.rd_valid = 1'b1;
      bus.wr_addr = '0;
      bus.rd_addr = '0;
      bus.wr_data = '1;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
      model_reset();
      #1 rst = 1'b1;
      #1 chk_reset_outputs();
      @(posedge clk); #1;
      pre = 1'b0;
`ifdef SRAM_ARB_INIT_EN
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      init_seq(4);
      rst = 1'b1;
      #1 chk_reset_outputs();
      model_reset();
      release_rst();
      cycle(1'b0, 1'b1, 3'd0, 3'd5, '0, 1'b1);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b0);
      chk("init_read5", bus.resp_data, '0);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
`else
      release_rst();
`endif
      // Write then read of the same address in consecutive cycles.
      cycle(1'b1, 1'b0, 3'd3, 3'd0, A5, 1'b1);
      chk("wr_granted", DW'(dut_gw), DW'(1));
      cycle(1'b0, 1'b1, 3'd0, 3'd3, '0, 1'b1);
      chk("rd_granted", DW'(dut_gr), DW'(1));
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b0);
      chk("wr_rd_valid_n3", DW'(bus.resp_valid), DW'(1));
      chk("wr_rd_data_n3", bus.resp_data, A5);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      // Contention with both valids held high.
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, AW'(i), AW'(i + 1), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
         if (i == 0) chk("contend_first_w", DW'(dut_gw), DW'(1));
         if (i == 1) chk("contend_then_r", DW'(dut_gr), DW'(1));
      end
      // Backpressure on a held response.
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      cycle(1'b0, 1'b1, 3'd0, 3'd5, '0, 1'b0);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b0);
      snap = bus.resp_data;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, AW'($urandom), 3'd5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
         chk("bp_data_stable", bus.resp_data, snap);
         chk("bp_write_taken", DW'(dut_gw), DW'(1));
      end
      cycle(1'b0, 1'b1, 3'd0, 3'd2, '0, 1'b1);
      chk("bp_release_read", DW'(dut_gr), DW'(1));
      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) != 0);
      chk("never_two_ops", DW'(dut_both), '0);
      // Reset with a read in flight.
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      cycle(1'b0, 1'b1, 3'd0, 3'd6, '0, 1'b1);
      bus.wr_valid = 1'b1;
      bus.rd_valid = 1'b1;
      rst = 1'b1;
      #1 chk_reset_outputs();
      model_reset();
      release_rst();
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      chk("aborted_read_dropped", DW'(bus.resp_valid), '0);
      cycle(1'b1, 1'b1, 3'd1, 3'd2, A5, 1'b1);
      chk("prio_after_reset_w", DW'(dut_gw), DW'(1));
      cycle(1'b0, 1'b0, 3'd0, 3'd0, '0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
